// File: rtl/sfr_arb.sv
// sfr_arb: two-port (CPU / monitor) arbiter and sequencer for the SFR block.
// One transaction at a time: latch in IDLE, drive SFR for one ACCESS cycle,
// capture read data, then pulse the granted port's ack in DONE.
module sfr_arb #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned PRIO_CPU = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_wen,
  input  logic [3:0]       cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_ack,
  input  logic             mon_req,
  input  logic             mon_wen,
  input  logic [3:0]       mon_addr,
  input  logic [WIDTH-1:0] mon_wdata,
  output logic             mon_ack,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             gnt,
  output logic [3:0]       sfr_addr,
  output logic             sfr_cen,
  output logic             sfr_wen,
  output logic [WIDTH-1:0] sfr_din,
  input  logic [WIDTH-1:0] sfr_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_gnt;
  logic   wen_q;
  logic   grant_en;
  logic   win;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and arbitration decision (requests only considered in IDLE)
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    win       = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || mon_req) begin
          grant_en  = 1'b1;
          state_nxt = ACCESS;
          if (cpu_req && mon_req) win = (PRIO_CPU != 0) ? 1'b0 : ~last_gnt;
          else                    win = mon_req;
        end
      end
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction latch, read-data capture and registered acks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      sfr_addr <= '0;
      sfr_din  <= '0;
      wen_q    <= 1'b0;
      rdata    <= '0;
      cpu_ack  <= 1'b0;
      mon_ack  <= 1'b0;
    end else begin
      if (grant_en) begin
        gnt      <= win;
        last_gnt <= win;
        sfr_addr <= win ? mon_addr  : cpu_addr;
        sfr_din  <= win ? mon_wdata : cpu_wdata;
        wen_q    <= win ? mon_wen   : cpu_wen;
      end
      if (state == ACCESS) rdata <= sfr_dout;
      // ack flops load on leaving ACCESS so they are high exactly in DONE
      cpu_ack <= (state == ACCESS) && !gnt;
      mon_ack <= (state == ACCESS) &&  gnt;
    end
  end

  // SFR strobes and busy decode
  always_comb begin
    busy    = (state != IDLE);
    sfr_cen = (state == ACCESS);
    sfr_wen = (state == ACCESS) && wen_q;
  end

endmodule

// File: tb/tb_sfr_arb.sv
// Bench for sfr_arb: two instances (round-robin and CPU-priority) share one
// stimulus; a transaction-level model predicts every output every cycle.
module tb_sfr_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_wen = 1'b0;
  logic [3:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        mon_req = 1'b0, mon_wen = 1'b0;
  logic [3:0]  mon_addr = '0;
  logic [31:0] mon_wdata = '0;

  logic        cpu_ack_w [2];
  logic        mon_ack_w [2];
  logic [31:0] rdata_w   [2];
  logic        busy_w    [2];
  logic        gnt_w     [2];
  logic [3:0]  addr_w    [2];
  logic        cen_w     [2];
  logic        wen_w     [2];
  logic [31:0] din_w     [2];
  logic [31:0] dout_w    [2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // SFR environment: base pattern plus written overlay, per instance
  bit [31:0] ev [2][16];
  bit        ew [2][16];

  function automatic logic [31:0] base(input logic [3:0] a);
    logic [7:0] b;
    b = {4'h0, a};
    return {b - 8'd1, b, b + 8'd1, b + 8'd2};
  endfunction

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sfr_arb #(.WIDTH(32), .PRIO_CPU(g)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack_w[g]),
      .mon_req(mon_req), .mon_wen(mon_wen), .mon_addr(mon_addr),
      .mon_wdata(mon_wdata), .mon_ack(mon_ack_w[g]),
      .rdata(rdata_w[g]), .busy(busy_w[g]), .gnt(gnt_w[g]),
      .sfr_addr(addr_w[g]), .sfr_cen(cen_w[g]), .sfr_wen(wen_w[g]),
      .sfr_din(din_w[g]), .sfr_dout(dout_w[g])
    );
    assign dout_w[g] = ew[g][addr_w[g]] ? ev[g][addr_w[g]] : base(addr_w[g]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (cen_w[i] && wen_w[i]) begin
        ev[i][addr_w[i]] <= din_w[i];
        ew[i][addr_w[i]] <= 1'b1;
      end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: a grant at edge number s means ACCESS in the cycle
  // after edge s, DONE one cycle later, and sampling resumes at edge s+3.
  int          cyc;
  int          s_m    [2];
  logic        last_m [2];
  logic        port_m [2];
  logic [3:0]  addr_m [2];
  logic [31:0] din_m  [2];
  logic        wen_m  [2];
  logic [31:0] rd_m   [2];
  bit   [31:0] mv [2][16];
  bit          mw [2][16];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= 0;
      for (int i = 0; i < 2; i++) begin
        s_m[i] <= -10; last_m[i] <= 1'b1; port_m[i] <= 1'b0;
        addr_m[i] <= '0; din_m[i] <= '0; wen_m[i] <= 1'b0; rd_m[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int   ph;
        logic p;
        ph = cyc - s_m[i];
        if (ph == 0) begin
          rd_m[i] <= mw[i][addr_m[i]] ? mv[i][addr_m[i]] : base(addr_m[i]);
          if (wen_m[i]) begin
            mv[i][addr_m[i]] <= din_m[i];
            mw[i][addr_m[i]] <= 1'b1;
          end
        end else if (ph >= 2 && (cpu_req || mon_req)) begin
          if (cpu_req && mon_req) p = (i == 1) ? 1'b0 : ~last_m[i];
          else                    p = mon_req;
          port_m[i] <= p;
          last_m[i] <= p;
          addr_m[i] <= p ? mon_addr  : cpu_addr;
          din_m[i]  <= p ? mon_wdata : cpu_wdata;
          wen_m[i]  <= p ? mon_wen   : cpu_wen;
          s_m[i]    <= cyc + 1;
        end
      end
      cyc <= cyc + 1;
    end
  end

  // Compare every cycle, mid-cycle, against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        int ph;
        ph = cyc - s_m[i];
        chk($sformatf("i%0d busy", i), 32'(busy_w[i]), 32'(ph == 0 || ph == 1));
        chk($sformatf("i%0d cen", i), 32'(cen_w[i]), 32'(ph == 0));
        chk($sformatf("i%0d sfr_wen", i), 32'(wen_w[i]), 32'(ph == 0 && wen_m[i]));
        chk($sformatf("i%0d sfr_addr", i), 32'(addr_w[i]), 32'(addr_m[i]));
        chk($sformatf("i%0d sfr_din", i), din_w[i], din_m[i]);
        chk($sformatf("i%0d gnt", i), 32'(gnt_w[i]), 32'(port_m[i]));
        chk($sformatf("i%0d cpu_ack", i), 32'(cpu_ack_w[i]), 32'(ph == 1 && !port_m[i]));
        chk($sformatf("i%0d mon_ack", i), 32'(mon_ack_w[i]), 32'(ph == 1 && port_m[i]));
        if (ph == 1) chk($sformatf("i%0d rdata", i), rdata_w[i], rd_m[i]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 reset = 1'b1;
    tick(2);
    reset = 1'b0;
    cmp_en = 1'b1;
    tick(1);

    // CPU read pulse at addr 1
    cpu_req = 1'b1; cpu_addr = 4'd1; cpu_wen = 1'b0; cpu_wdata = 32'h5555_AAAA;
    tick(1);
    cpu_req = 1'b0;
    chk("rd cen c1", 32'(cen_w[0]), 32'd1);
    chk("rd addr c1", 32'(addr_w[0]), 32'd1);
    tick(1);
    chk("rd cpu_ack c2", 32'(cpu_ack_w[0]), 32'd1);
    chk("rd rdata c2", rdata_w[0], 32'h0001_0203);
    chk("rd mon_ack c2", 32'(mon_ack_w[0]), 32'd0);
    tick(1);

    // Monitor write; fields change after grant
    mon_req = 1'b1; mon_wen = 1'b1; mon_addr = 4'd5; mon_wdata = 32'hDEAD_BEEF;
    tick(1);
    mon_req = 1'b0; mon_wdata = 32'h0; mon_addr = 4'd0; mon_wen = 1'b0;
    chk("wr sfr_wen c1", 32'(wen_w[0]), 32'd1);
    chk("wr din c1", din_w[0], 32'hDEAD_BEEF);
    chk("wr addr c1", 32'(addr_w[0]), 32'd5);
    tick(1);
    chk("wr mon_ack c2", 32'(mon_ack_w[1]), 32'd1);
    chk("wr sfr_wen c2", 32'(wen_w[1]), 32'd0);
    chk("wr rdata c2", rdata_w[1], 32'h0405_0607);
    tick(2);

    // Mid-cycle reset with no requests
    #2 reset = 1'b1;
    #1;
    chk("rst gnt", 32'(gnt_w[0]), 32'd0);
    chk("rst sfr_addr", 32'(addr_w[0]), 32'd0);
    chk("rst sfr_din", din_w[0], 32'd0);
    chk("rst rdata", rdata_w[0], 32'd0);
    chk("rst busy", 32'(busy_w[1]), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(1);

    // Both ports requesting continuously
    cpu_req = 1'b1; cpu_addr = 4'd2; cpu_wen = 1'b0;
    mon_req = 1'b1; mon_addr = 4'd3; mon_wen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk($sformatf("rr addr k%0d", k), 32'(addr_w[0]), (k % 2 == 0) ? 32'd2 : 32'd3);
      chk($sformatf("fp addr k%0d", k), 32'(addr_w[1]), 32'd2);
      tick(1);
      chk($sformatf("rr cpu_ack k%0d", k), 32'(cpu_ack_w[0]), 32'(k % 2 == 0));
      chk($sformatf("rr mon_ack k%0d", k), 32'(mon_ack_w[0]), 32'(k % 2 == 1));
      chk($sformatf("fp cpu_ack k%0d", k), 32'(cpu_ack_w[1]), 32'd1);
      if (k == 3) cpu_req = 1'b0;
      tick(1);
    end
    tick(2);
    chk("fp mon_ack after drop", 32'(mon_ack_w[1]), 32'd1);
    chk("rr mon_ack after drop", 32'(mon_ack_w[0]), 32'd1);
    mon_req = 1'b0;
    tick(2);

    // Reset during ACCESS of a write
    cpu_req = 1'b1; cpu_addr = 4'd7; cpu_wen = 1'b1; cpu_wdata = 32'h1234_5678;
    tick(1);
    chk("ra cen before", 32'(cen_w[0]), 32'd1);
    #2 reset = 1'b1; cpu_req = 1'b0;
    #1;
    chk("ra cen after", 32'(cen_w[0]), 32'd0);
    chk("ra busy after", 32'(busy_w[1]), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(3);
    cpu_req = 1'b1; cpu_addr = 4'd1; cpu_wen = 1'b0;
    tick(1);
    cpu_req = 1'b0;
    chk("post cen c1", 32'(cen_w[1]), 32'd1);
    tick(1);
    chk("post cpu_ack c2", 32'(cpu_ack_w[1]), 32'd1);
    chk("post rdata c2", rdata_w[1], 32'h0001_0203);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
